// File: rtl/opcode_encode.sv
// rtl/opcode_encode.sv - 6502-style instruction encoder emitting opcode/operand bytes
//
// Purpose: accepts one instruction request (operation group aaa, column group
// cc, addressing mode, operand), validates the combination, builds the opcode
// {aaa,bbb,cc} and emits 1..3 bytes on a valid/ready byte stream, each tagged
// with the running emission address pc.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready request handshake (ready only in IDLE with pc_load low)
//   aaa, cc, mode     opcode groups and addressing mode
//   operand           immediate/address; absolute branch target for REL
//   pc_load, pc_in    load the emission address counter while idle
//   out_valid/ready   byte stream handshake
//   out_data          emitted byte
//   out_addr          address of the emitted byte (current pc)
//   out_last          marks the final byte of an instruction
//   err               one-cycle pulse after a rejected request
module opcode_encode (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  aaa,
  input  logic [1:0]  cc,
  input  logic [3:0]  mode,
  input  logic [15:0] operand,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [15:0] out_addr,
  output logic        out_last,
  output logic        err
);

  localparam logic [3:0] M_IMP0 = 4'd0,  M_IMP2 = 4'd1,  M_ACC  = 4'd2,
                         M_IMP6 = 4'd3,  M_IMM  = 4'd4,  M_ZPG  = 4'd5,
                         M_ZPX  = 4'd6,  M_ZPY  = 4'd7,  M_ABS  = 4'd8,
                         M_ABX  = 4'd9,  M_ABY  = 4'd10, M_XIND = 4'd11,
                         M_INDY = 4'd12, M_IND  = 4'd13, M_REL  = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_OP, S_LO, S_HI} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc;
  logic [7:0]  op_reg, lo_reg, hi_reg;
  logic [1:0]  len_reg;

  logic [2:0]  bbb;
  logic [1:0]  len;
  logic        illegal;
  logic [15:0] rel_diff;
  logic        rel_ok;
  logic        x_or_y_load;
  logic        accept, handshake;

  // Branch offset is relative to the address after the 2-byte branch.
  assign rel_diff = operand - (pc + 16'd2);
  // Fits in a signed byte only if bits [15:7] are all equal.
  assign rel_ok   = (rel_diff[15:7] == 9'h000) || (rel_diff[15:7] == 9'h1FF);
  // cc=10 with an index-Y mode is only meaningful for the LDX/STX groups.
  assign x_or_y_load = (aaa == 3'b100) || (aaa == 3'b101);

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // Mode decode: bbb field, instruction length and legality.
  always_comb begin
    bbb     = 3'b000;
    len     = 2'd1;
    illegal = 1'b0;
    case (mode)
      M_IMP0: begin bbb = 3'b000; len = 2'd1; end
      M_IMP2: begin bbb = 3'b010; len = 2'd1; end
      M_ACC:  begin bbb = 3'b010; len = 2'd1; illegal = (cc != 2'b10); end
      M_IMP6: begin bbb = 3'b110; len = 2'd1; end
      M_IMM:  begin bbb = (cc == 2'b01) ? 3'b010 : 3'b000; len = 2'd2; end
      M_ZPG:  begin bbb = 3'b001; len = 2'd2; end
      M_ZPX:  begin bbb = 3'b101; len = 2'd2; end
      M_ZPY:  begin bbb = 3'b101; len = 2'd2; illegal = (cc != 2'b10) || !x_or_y_load; end
      M_ABS:  begin bbb = 3'b011; len = 2'd3; end
      M_ABX:  begin bbb = 3'b111; len = 2'd3; end
      M_ABY:  begin
        bbb     = (cc == 2'b01) ? 3'b110 : 3'b111;
        len     = 2'd3;
        illegal = (cc == 2'b10) && !x_or_y_load;
      end
      M_XIND: begin bbb = 3'b000; len = 2'd2; illegal = (cc != 2'b01); end
      M_INDY: begin bbb = 3'b100; len = 2'd2; illegal = (cc != 2'b01); end
      M_IND:  begin bbb = 3'b011; len = 2'd3; illegal = !((aaa == 3'b011) && (cc == 2'b00)); end
      M_REL:  begin bbb = 3'b100; len = 2'd2; illegal = (cc != 2'b00) || !rel_ok; end
      default: illegal = 1'b1;
    endcase
    if (cc == 2'b11) illegal = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && !illegal) state_nxt = S_OP;
      S_OP:   if (handshake) state_nxt = (len_reg == 2'd1) ? S_IDLE : S_LO;
      S_LO:   if (handshake) state_nxt = (len_reg == 2'd2) ? S_IDLE : S_HI;
      S_HI:   if (handshake) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = (state == S_IDLE) && !pc_load;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state)
      S_OP: begin out_valid = 1'b1; out_data = op_reg; out_last = (len_reg == 2'd1); end
      S_LO: begin out_valid = 1'b1; out_data = lo_reg; out_last = (len_reg == 2'd2); end
      S_HI: begin out_valid = 1'b1; out_data = hi_reg; out_last = 1'b1; end
      default: ;
    endcase
  end

  assign out_addr = pc;

  // Datapath: latched instruction, emission address and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= 16'h0000;
      op_reg  <= 8'h00;
      lo_reg  <= 8'h00;
      hi_reg  <= 8'h00;
      len_reg <= 2'd1;
      err     <= 1'b0;
    end else begin
      err <= accept && illegal;
      if (accept && !illegal) begin
        op_reg  <= {aaa, bbb, cc};
        lo_reg  <= (mode == M_REL) ? rel_diff[7:0] : operand[7:0];
        hi_reg  <= operand[15:8];
        len_reg <= len;
      end
      if ((state == S_IDLE) && pc_load) pc <= pc_in;
      else if (handshake)               pc <= pc + 16'd1;
    end
  end

endmodule
